// File: rtl/calc_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency calculator between NUM_REQ requesters.
// One operation in flight; each result is returned as a one-cycle pulse to its owner.
module calc_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*8-1:0]   req_operand_A,
  input  logic [NUM_REQ*8-1:0]   req_operand_B,
  input  logic [NUM_REQ*2-1:0]   req_op_code,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_result,
  output logic [7:0]             calc_operand_A,
  output logic [7:0]             calc_operand_B,
  output logic [1:0]             calc_op_code,
  output logic                   calc_start,
  input  logic [15:0]            calc_result,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_r;
  logic [IW-1:0] gnt_s;
  logic          found_s;
  int            idx_s;

  // Search downward from the farthest offset so the lowest offset from rr_ptr wins.
  always_comb begin
    found_s = 1'b0;
    gnt_s   = {IW{1'b0}};
    idx_s   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_s   = int'(rr_ptr) + k;
      idx_s   = (idx_s >= NUM_REQ) ? (idx_s - NUM_REQ) : idx_s;
      gnt_s   = req_valid[idx_s] ? idx_s[IW-1:0] : gnt_s;
      found_s = found_s | req_valid[idx_s];
    end
  end

  assign req_ready = ((state == IDLE) && found_s) ? (ONE_HOT0 << gnt_s) : {NUM_REQ{1'b0}};
  assign busy      = (state != IDLE);

  // FSM, operand latch, wait counter, result capture and response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= 4'd0;
      rr_ptr         <= {IW{1'b0}};
      gnt_r          <= {IW{1'b0}};
      calc_operand_A <= 8'd0;
      calc_operand_B <= 8'd0;
      calc_op_code   <= 2'd0;
      calc_start     <= 1'b0;
      rsp_valid      <= {NUM_REQ{1'b0}};
      rsp_result     <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found_s) begin
            calc_operand_A <= req_operand_A[gnt_s*8 +: 8];
            calc_operand_B <= req_operand_B[gnt_s*8 +: 8];
            calc_op_code   <= req_op_code[gnt_s*2 +: 2];
            gnt_r          <= gnt_s;
            calc_start     <= 1'b1;
            state          <= ISSUE;
          end else begin
            state          <= IDLE;
          end
        end
        ISSUE: begin
          calc_start <= 1'b0;
          wait_cnt   <= 4'(LATENCY);
          state      <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            rsp_result <= calc_result;
            rsp_valid  <= ONE_HOT0 << gnt_r;
            state      <= RESP;
          end else begin
            state      <= WAIT;
          end
        end
        RESP: begin
          rsp_valid <= {NUM_REQ{1'b0}};
          rr_ptr    <= (gnt_r == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : (gnt_r + IW'(1));
          state     <= IDLE;
        end
        default: begin
          calc_start <= 1'b0;
          rsp_valid  <= {NUM_REQ{1'b0}};
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_rr_scheduler.sv
// Directed bench for calc_rr_scheduler: one instance at LATENCY=1, one at LATENCY=4,
// each driven by a simple fixed-latency calculator stand-in.
module tb_calc_rr_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  req_valid1 = 4'd0, req_ready1, rsp_valid1;
  logic [31:0] req_A1 = 32'd0, req_B1 = 32'd0;
  logic [7:0]  req_op1 = 8'd0;
  logic [15:0] rsp_result1, calc_result1;
  logic [7:0]  calc_A1, calc_B1;
  logic [1:0]  calc_op1;
  logic        calc_start1, busy1;

  logic [3:0]  req_valid4 = 4'd0, req_ready4, rsp_valid4;
  logic [31:0] req_A4 = 32'd0, req_B4 = 32'd0;
  logic [7:0]  req_op4 = 8'd0;
  logic [15:0] rsp_result4, calc_result4;
  logic [7:0]  calc_A4, calc_B4;
  logic [1:0]  calc_op4;
  logic        calc_start4, busy4;

  calc_rr_scheduler #(.NUM_REQ(4), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_operand_A(req_A1), .req_operand_B(req_B1), .req_op_code(req_op1),
    .rsp_valid(rsp_valid1), .rsp_result(rsp_result1),
    .calc_operand_A(calc_A1), .calc_operand_B(calc_B1), .calc_op_code(calc_op1),
    .calc_start(calc_start1), .calc_result(calc_result1), .busy(busy1));

  calc_rr_scheduler #(.NUM_REQ(4), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_operand_A(req_A4), .req_operand_B(req_B4), .req_op_code(req_op4),
    .rsp_valid(rsp_valid4), .rsp_result(rsp_result4),
    .calc_operand_A(calc_A4), .calc_operand_B(calc_B4), .calc_op_code(calc_op4),
    .calc_start(calc_start4), .calc_result(calc_result4), .busy(busy4));

  function automatic logic [15:0] calc_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return {8'h00, a} + {8'h00, b};
      2'b01:   return {8'h00, a} - {8'h00, b};
      2'b10:   return {8'h00, a} * {8'h00, b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // Calculator stand-in: result is valid only exactly LATENCY cycles after calc_start.
  int since1 = 100, since4 = 100;
  always @(posedge clk) begin
    since1 <= calc_start1 ? 1 : ((since1 < 100) ? since1 + 1 : 100);
    since4 <= calc_start4 ? 1 : ((since4 < 100) ? since4 + 1 : 100);
  end
  assign calc_result1 = (since1 == 1) ? calc_f(calc_A1, calc_B1, calc_op1) : 16'hBAD0;
  assign calc_result4 = (since4 == 4) ? calc_f(calc_A4, calc_B4, calc_op4) : 16'hBAD0;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pay1(input int id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_A1[id*8 +: 8] = a;
    req_B1[id*8 +: 8] = b;
    req_op1[id*2 +: 2] = op;
  endtask

  task automatic wait_rsp1(output logic [3:0] v, output logic [15:0] r);
    v = 4'd0;
    r = 16'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid1 != 4'd0) begin
        v = rsp_valid1;
        r = rsp_result1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL rsp_timeout: no rsp_valid within 20 cycles");
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic [15:0] res;
  } vec_t;
  vec_t vecs[5];

  logic [3:0]  v;
  logic [15:0] r;
  int          nrsp;

  initial begin
    vecs[0] = '{0, 8'd12,  8'd30,  2'b00, 16'd42};
    vecs[1] = '{1, 8'd200, 8'd100, 2'b00, 16'd300};
    vecs[2] = '{2, 8'd50,  8'd70,  2'b01, 16'hFFEC};
    vecs[3] = '{3, 8'd16,  8'd16,  2'b10, 16'd256};
    vecs[4] = '{1, 8'hA5,  8'h0F,  2'b11, 16'h00AA};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_calc", {14'd0, calc_start1, calc_A1, calc_B1, calc_op1}, 32'd0);
    chk("rst_rsp", {12'd0, rsp_valid1, rsp_result1}, 32'd0);
    chk("rst_ready", {28'd0, req_ready1}, 32'd0);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requests, cycle-accurate
    for (int i = 0; i < 5; i++) begin
      set_pay1(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      req_valid1 = 4'b0001 << vecs[i].id;
      #1;
      chk("c0_ready", {28'd0, req_ready1}, {28'd0, 4'b0001 << vecs[i].id});
      @(negedge clk);
      req_valid1 = 4'd0;
      chk("c1_start", {31'd0, calc_start1}, 32'd1);
      chk("c1_calc", {14'd0, busy1, calc_A1, calc_B1, calc_op1}, {14'd0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op});
      @(negedge clk);
      chk("c2_start_rsp", {27'd0, calc_start1, rsp_valid1}, 32'd0);
      @(negedge clk);
      chk("c3_rsp_valid", {28'd0, rsp_valid1}, {28'd0, 4'b0001 << vecs[i].id});
      chk("c3_rsp_result", {16'd0, rsp_result1}, {16'd0, vecs[i].res});
      @(negedge clk);
      chk("c4_idle", {27'd0, busy1, rsp_valid1}, 32'd0);
      chk("c4_result_kept", {16'd0, rsp_result1}, {16'd0, vecs[i].res});
    end

    // Last grant was 1, so rr_ptr=2: with 0 and 3 valid, 3 wins first
    set_pay1(0, 8'd1, 8'd2, 2'b00);
    set_pay1(3, 8'd9, 8'd3, 2'b01);
    req_valid1 = 4'b1001;
    wait_rsp1(v, r);
    chk("ptr2_first", {12'd0, v, r}, {12'd0, 4'b1000, 16'd6});
    req_valid1 = 4'b0001;
    wait_rsp1(v, r);
    chk("ptr2_second", {12'd0, v, r}, {12'd0, 4'b0001, 16'd3});
    req_valid1 = 4'd0;

    // Requester 0 re-asserts in its own RESP cycle while 1 waits: 1 goes next
    @(negedge clk);
    req_valid1 = 4'b0001;
    #1;
    chk("re_ready0", {28'd0, req_ready1}, 32'd1);
    @(negedge clk);
    req_valid1 = 4'b0010;
    chk("re_busy_no_ready", {28'd0, req_ready1}, 32'd0);
    wait_rsp1(v, r);
    chk("re_first", {28'd0, v}, 32'd1);
    req_valid1 = 4'b0011;
    wait_rsp1(v, r);
    chk("re_second", {28'd0, v}, 32'd2);
    req_valid1 = 4'b0001;
    wait_rsp1(v, r);
    chk("re_third", {28'd0, v}, 32'd1);
    req_valid1 = 4'd0;

    // All four continuously valid from reset: strict rotation 0,1,2,3,0,1,2,3
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_pay1(i, 8'(10 + i), 8'(i), 2'b00);
    req_valid1 = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wait_rsp1(v, r);
      chk("rr_owner", {28'd0, v}, {28'd0, 4'b0001 << (n % 4)});
      chk("rr_result", {16'd0, r}, 32'(10 + 2 * (n % 4)));
    end
    req_valid1 = 4'd0;

    // LATENCY=4: calc_* stable for 5 cycles, response in cycle 6
    @(negedge clk);
    req_A4[7:0] = 8'hFF;
    req_B4[7:0] = 8'hFF;
    req_op4[1:0] = 2'b10;
    req_valid4 = 4'b0001;
    #1;
    chk("l4_ready", {28'd0, req_ready4}, 32'd1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req_valid4 = 4'd0;
      if (c <= 5) begin
        chk("l4_calc", {13'd0, busy4, calc_start4, calc_A4, calc_B4, calc_op4},
            {13'd0, 1'b1, (c == 1), 8'hFF, 8'hFF, 2'b10});
        chk("l4_no_rsp", {28'd0, rsp_valid4}, 32'd0);
      end else if (c == 6) begin
        chk("l4_rsp", {11'd0, busy4, rsp_valid4, rsp_result4}, {11'd0, 1'b1, 4'b0001, 16'hFE01});
      end else begin
        chk("l4_done", {27'd0, busy4, rsp_valid4}, 32'd0);
      end
    end

    // Reset during WAIT of a requester-1 operation
    req_A4[15:8] = 8'd3;
    req_B4[15:8] = 8'd4;
    req_op4[3:2] = 2'b00;
    req_valid4 = 4'b0010;
    @(negedge clk);
    req_valid4 = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_in_wait", {31'd0, busy4}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_calc", {14'd0, calc_start4, calc_A4, calc_B4, calc_op4}, 32'd0);
    chk("mid_rst_rsp", {11'd0, busy4, rsp_valid4, rsp_result4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid4 != 4'd0) nrsp++;
    end
    chk("mid_no_rsp", 32'(nrsp), 32'd0);
    req_A4[23:16] = 8'd7;
    req_B4[23:16] = 8'd6;
    req_op4[5:4] = 2'b10;
    req_valid4 = 4'b0100;
    #1;
    chk("after_rst_ready", {28'd0, req_ready4}, 32'd4);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_valid4 = 4'd0;
    end
    chk("after_rst_rsp", {12'd0, rsp_valid4, rsp_result4}, {12'd0, 4'b0100, 16'd42});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_rr_scheduler.md
Name: calc_rr_scheduler

Overview:
- Shares one calculator datapath (8-bit operand A, 8-bit operand B, 2-bit op code, 16-bit result) between NUM_REQ requesters.
- Each request is accepted with a valid/ready handshake and chosen by round-robin arbitration.
- The block issues the operation to the calculator, waits a fixed LATENCY, captures the result and returns it to the granted requester as a one-cycle response pulse.
- It sits between the testbench/host agents and the calculator core; only one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- LATENCY, 1, cycles from calc_start to a valid calc_result; legal range 1..15.

Ports:
- clk, input, 1, single clock; all state is updated on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NUM_REQ, per-requester request valid.
- req_ready, output, NUM_REQ, per-requester accept; at most one bit is set.
- req_operand_A, input, NUM_REQ*8, packed operand A; requester i uses bits [i*8+:8].
- req_operand_B, input, NUM_REQ*8, packed operand B; requester i uses bits [i*8+:8].
- req_op_code, input, NUM_REQ*2, packed op code; requester i uses bits [i*2+:2].
- rsp_valid, output, NUM_REQ, one-hot, one-cycle pulse marking the result owner.
- rsp_result, output, 16, result; meaningful while any rsp_valid bit is high.
- calc_operand_A, output, 8, operand A driven to the calculator.
- calc_operand_B, output, 8, operand B driven to the calculator.
- calc_op_code, output, 2, op code driven to the calculator.
- calc_start, output, 1, one-cycle pulse that launches a calculator operation.
- calc_result, input, 16, calculator result; valid LATENCY cycles after calc_start.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; wait counter=0; all outputs 0, including calc_* and rsp_result.
- Reset mid-operation: the in-flight op is dropped, no rsp_valid is produced, and the calc_* outputs return to 0 immediately.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration:
  - If any req_valid is high, grant g = the first requester with valid set, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in IDLE only; all other ready bits are 0.
  - On the edge where req_valid[g] && req_ready[g]: latch requester g's operands and op code plus the grant index, then go to ISSUE.
  - If no req_valid bit is set, stay in IDLE with all ready bits at 0.
- ISSUE (1 cycle): calc_start=1; calc_* driven from the latched registers; go to WAIT with counter=LATENCY.
- WAIT (LATENCY cycles): calc_* held stable; counter decrements each cycle. In the cycle where counter==1, calc_result is sampled into the result register at the closing edge, then go to RESP.
- RESP (1 cycle):
  - rsp_valid[g]=1 and rsp_result = captured value.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Go to IDLE.
  - No backpressure: the requester must accept the pulse.
- Timing: handshake in cycle 0 -> calc_start in cycle 1 -> rsp_valid in cycle LATENCY+2 -> earliest next handshake in cycle LATENCY+3. Throughput is one op per LATENCY+3 cycles.
- Requester rules: once a requester raises req_valid, it holds valid and payload stable until ready. A requester may raise a new request in its own RESP cycle; that request is visible in the next IDLE.
- Fairness: a requester that is continuously valid is granted within NUM_REQ operations. The last-granted requester has the lowest priority next round.
- Opcode: passed through without interpretation; the scheduler never checks the op code.
- rsp_result keeps its last value outside RESP; rsp_valid is all-zero outside RESP.
- busy = (state != IDLE).

Test Plan:
- Single request: LATENCY=1, req 0 sends A=8'd12, B=8'd30, op=2'b00, calculator model returns 16'd42 -> req_ready[0] in cycle 0, calc_start in cycle 1, rsp_valid=4'b0001 with rsp_result=16'd42 in cycle 3.
- All four requesters valid continuously from reset, 8 ops -> grant order 0,1,2,3,0,1,2,3; each rsp_valid goes to the matching owner.
- rr_ptr=2 (after a grant to 1), requesters 0 and 3 valid -> 3 is granted before 0.
- LATENCY=4, A=8'hFF, B=8'hFF, op=2'b10, model returns 16'hFE01 -> calc_* stable for 5 cycles, rsp_result=16'hFE01 in cycle 6, busy high for cycles 1..6.
- rst_n asserted during WAIT of a req 1 op -> no rsp_valid; all outputs 0 and rr_ptr=0 after release; a new req 2 is served normally.
- Requester 0 re-asserts valid in its own RESP cycle while requester 1 is also valid -> requester 1 is granted next.
